nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle subtractor that computes `a - b` for WIDTH-bit operands four bits per clock, using 4-bit borrow-lookahead per nibble and a registered borrow chained between nibbles. It is the subtract-direction companion to the team's 4-bit carry-lookahead adder. It serves datapaths where a wide subtraction can trade latency for area. Control is a start/busy/done handshake; results are registered and held until the next accepted start.

## Interface
- `WIDTH`, default 16: operand and result width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 is the nibble count.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a subtraction; sampled on `clk` edges.
- `a`  in  WIDTH  minuend, captured on the accepting edge.
- `b`  in  WIDTH  subtrahend, captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result is valid.
- `diff`  out  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  out  1  final borrow; 1 iff a < b unsigned.
- `ovf`  out  1  signed two's-complement overflow.
- `zero`  out  1  1 iff diff == 0.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: processes one nibble per edge; nibble index runs 0..N-1.
  - DONE: lasts one cycle.
- IDLE or DONE, with `start`=1 on an edge:
  - Latch `a` and `b`.
  - Clear the internal borrow and the nibble index.
  - Go to RUN.
- DONE with `start`=0: return to IDLE.
- `start` is ignored in RUN. Operands are not re-sampled and the operation in flight is unaffected.
- RUN, nibble i, per edge:
  - Form the inverted subtrahend nb = ~b[4i+3:4i] and cin = ~borrow_reg.
  - Generate p = a_nib ^ nb and g = a_nib & nb.
  - Compute lookahead carries c0..c3 from g, p and cin.
  - Write diff[4i+3:4i] = p ^ {c2, c1, c0, cin}.
  - Set borrow_reg <= ~c3.
  - When i = N-1, go to DONE.
- Result flags are registered on the edge that writes nibble N-1:
  - `borrow` = ~c3 of the top nibble.
  - `ovf` = carry into the MSB XOR carry out of the MSB.
  - `zero` = all diff bits zero, including the nibble just written.
- `diff`, `borrow`, `ovf` and `zero` hold their values through DONE and IDLE until the next accepted start.
- Nibbles of `diff` above the current index keep their previous values during RUN. `diff` is valid only when `done`=1 or afterwards.
- N = 1 (WIDTH = 4): a single RUN cycle, behaving as a registered 4-bit subtractor.

## Timing
- Reset (async assert, sync release behaviour is external):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0, `zero`=0.
  - Internal borrow and nibble index are cleared.
- Reset asserted mid-RUN aborts immediately; no `done` pulse is produced.
- Latency:
  - Accepting edge E0.
  - Nibbles are written on edges E1..EN.
  - `done`=1 for the single cycle following EN.
  - Total: N+1 edges from accept to `done` deasserting.
- `busy`: 1 from after E0 through EN, and 0 while `done`=1.
- Back-to-back: `start`=1 during the DONE cycle is accepted on the next edge. `done` then falls and `busy` rises on that edge, sustaining one result per N+1 cycles.
- `start` held high continuously re-triggers every N+1 cycles.
- No combinational path from any input to any output.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, start pulsed:
  - `busy` is high for 4 cycles.
  - `done` pulses on the 5th cycle after accept.
  - diff=0x1000, borrow=0, ovf=0, zero=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0, zero=0. Exercises borrow propagation across all nibbles.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1.
- a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
- a=b=0xABCD -> diff=0x0000, zero=1, borrow=0.
- Start while busy:
  - Accept a=5, b=3.
  - Two cycles later, pulse start with a=9, b=1.
  - Required: the second start is ignored; one `done` with diff=0x0002.
  - `start` in the DONE cycle with a=9, b=1 yields diff=0x0008 after a further N+1 cycles.
- Reset mid-op: assert `rst_n`=0 during the third RUN cycle.
  - All outputs are 0 immediately.
  - No `done` pulse.
  - After release, a fresh start computes correctly.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b, one 4-bit borrow-lookahead nibble per clock.
// Start/busy/done handshake; results held until the next accepted start.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] diff_next;
  logic [IW-1:0]    idx;
  logic             borrow_reg;
  logic             load, last;
  logic [3:0]       a_nib, nb, p, g, c, sum;
  logic             cin;

  assign last = (idx == IW'(N - 1));
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Subtract as a + ~b + 1, borrow being the inverted carry.
  always_comb begin
    a_sh  = a_reg >> {idx, 2'b00};
    b_sh  = b_reg >> {idx, 2'b00};
    a_nib = a_sh[3:0];
    nb    = ~b_sh[3:0];
    cin   = ~borrow_reg;
    p     = a_nib ^ nb;
    g     = a_nib & nb;
    c[0]  = g[0] | (p[0] & cin);
    c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & cin);
    c[3]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cin);
    sum   = p ^ {c[2:0], cin};
    diff_next = diff;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) diff_next[4*k +: 4] = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx        <= '0;
      borrow_reg <= 1'b0;
      diff       <= '0;
      borrow     <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else if (load) begin
      a_reg      <= a;
      b_reg      <= b;
      idx        <= '0;
      borrow_reg <= 1'b0;
    end else if (state == S_RUN) begin
      diff       <= diff_next;
      borrow_reg <= ~c[3];
      idx        <= idx + IW'(1);
      if (last) begin
        borrow <= ~c[3];
        ovf    <= c[3] ^ c[2];
        zero   <= (diff_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor at WIDTH=16.
// Expected results are queued at start and checked on each done pulse.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow, ovf, zero;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ndone = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.br = (x < y);
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    e.z  = (e.d == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      ndone++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = q.pop_front();
        check("diff",   32'(diff),   32'(e.d));
        check("borrow", 32'(borrow), 32'(e.br));
        check("ovf",    32'(ovf),    32'(e.ov));
        check("zero",   32'(zero),   32'(e.z));
      end
    end
  end

  // Called in the "#1 after posedge" phase; returns in the same phase.
  task automatic start_op(input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          input bit push);
    start = 1'b1;
    a     = x;
    b     = y;
    if (push) q.push_back(model(x, y));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int prev = ndone;
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ndone != prev) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int prev;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({borrow, ovf, zero}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Handshake timing: busy for 4 cycles, done on the 5th.
    start_op(16'h1234, 16'h0234, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", k), 32'(busy), 32'(k < 5));
      check($sformatf("done_c%0d", k), 32'(done), 32'(k == 5));
    end
    @(posedge clk);
    #1;

    start_op(16'h0000, 16'h0001, 1);
    wait_done();
    start_op(16'h8000, 16'h0001, 1);
    wait_done();
    start_op(16'h7FFF, 16'hFFFF, 1);
    wait_done();
    start_op(16'hABCD, 16'hABCD, 1);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      start_op(16'($urandom), 16'($urandom), 1);
      wait_done();
    end

    // Start while busy is ignored; start in DONE is accepted.
    prev = ndone;
    start_op(16'd5, 16'd3, 1);
    @(posedge clk);
    @(posedge clk);
    #1 start_op(16'd9, 16'd1, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("b2b_timeout", 32'd0, 32'd1);
    start = 1'b1;
    a     = 16'd9;
    b     = 16'd1;
    q.push_back(model(16'd9, 16'd1));
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    check("b2b_ndone", 32'(ndone - prev), 32'd1);
    wait_done();
    check("b2b_ndone2", 32'(ndone - prev), 32'd2);

    // Reset during the third RUN cycle aborts with no done.
    prev = ndone;
    start_op(16'h4444, 16'h1111, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_flags", 32'({borrow, ovf, zero}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_nodone", 32'(ndone - prev), 32'd0);
    start_op(16'h4444, 16'h1111, 1);
    wait_done();

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
